// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder with registered result and carry-event counter
//
// Purpose:
//   Combinational full adder (s, co) plus a registered copy of the result
//   qualified by in_vld, and a saturating count of accepted carry events.
//
// Ports:
//   clk        in   rising-edge clock for all registers
//   rst_n      in   asynchronous active-low reset
//   a, b, ci   in   addend bits and carry-in
//   in_vld     in   qualifies a/b/ci for the registered path and the counter
//   cnt_clr    in   synchronous clear of carry_cnt (wins over an increment)
//   s, co      out  combinational sum / carry-out
//   s_q, co_q  out  registered sum / carry-out, 1-cycle latency
//   out_vld    out  in_vld delayed by one cycle
//   carry_cnt  out  saturating count of accepted inputs with co=1

module full_adder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             ci,
  input  logic             in_vld,
  input  logic             cnt_clr,
  output logic             s,
  output logic             co,
  output logic             s_q,
  output logic             co_q,
  output logic             out_vld,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // The combinational path is independent of reset and qualifiers so s/co
  // keep tracking the inputs even while the registered state is held in reset.
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

  logic cnt_inc;
  assign cnt_inc = in_vld & co & (carry_cnt != CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= 1'b0;
      co_q      <= 1'b0;
      out_vld   <= 1'b0;
      carry_cnt <= '0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        s_q  <= s;
        co_q <= co;
      end
      // Clear has priority over a same-edge increment.
      if (cnt_clr) begin
        carry_cnt <= '0;
      end else if (cnt_inc) begin
        carry_cnt <= carry_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed self-checking bench for full_adder

module tb_full_adder;

  localparam int CNT_W = 8;

  logic             clk;
  logic             clk_en;
  logic             rst_n;
  logic             a;
  logic             b;
  logic             ci;
  logic             in_vld;
  logic             cnt_clr;
  logic             s;
  logic             co;
  logic             s_q;
  logic             co_q;
  logic             out_vld;
  logic [CNT_W-1:0] carry_cnt;

  int checks;
  int failures;

  full_adder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .in_vld    (in_vld),
    .cnt_clr   (cnt_clr),
    .s         (s),
    .co        (co),
    .s_q       (s_q),
    .co_q      (co_q),
    .out_vld   (out_vld),
    .carry_cnt (carry_cnt)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clocked transfer: drive at negedge, release qualifiers just after the edge.
  task automatic cycle(input logic va, input logic vb, input logic vci,
                       input logic vvld, input logic vclr);
    @(negedge clk);
    a = va; b = vb; ci = vci; in_vld = vvld; cnt_clr = vclr;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    cnt_clr = 1'b0;
  endtask

  // Hand-computed {co,s} for {a,b,ci} = 0..7.
  logic [1:0] exp_cs [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  logic [2:0] vec;

  initial begin
    checks = 0;
    failures = 0;
    clk_en = 1'b0;
    rst_n = 1'b0;
    a = 0; b = 0; ci = 0; in_vld = 0; cnt_clr = 0;
    #3;

    // Reset state, with no clock ever having toggled.
    check("rst_s_q", {31'd0, s_q}, 32'd0);
    check("rst_co_q", {31'd0, co_q}, 32'd0);
    check("rst_out_vld", {31'd0, out_vld}, 32'd0);
    check("rst_cnt", {24'd0, carry_cnt}, 32'd0);

    // Combinational truth table, no clock, reset held.
    for (int i = 0; i < 8; i++) begin
      vec = i[2:0];
      {a, b, ci} = vec;
      #100;
      check($sformatf("comb_%0d", i), {30'd0, co, s}, {30'd0, exp_cs[i]});
    end

    // Release reset away from any edge, then start the clock.
    a = 0; b = 0; ci = 0;
    #2 rst_n = 1'b1;
    clk_en = 1'b1;

    // First edge after reset: 1+1+0 -> s=0 co=1, counter increments.
    cycle(1, 1, 0, 1, 0);
    check("acc110_s_q", {31'd0, s_q}, 32'd0);
    check("acc110_co_q", {31'd0, co_q}, 32'd1);
    check("acc110_out_vld", {31'd0, out_vld}, 32'd1);
    check("acc110_cnt", {24'd0, carry_cnt}, 32'd1);

    // Accepted input with no carry: 1+0+0.
    cycle(1, 0, 0, 1, 0);
    check("acc100_s_q", {31'd0, s_q}, 32'd1);
    check("acc100_co_q", {31'd0, co_q}, 32'd0);
    check("acc100_cnt", {24'd0, carry_cnt}, 32'd1);

    // in_vld=0 with toggling inputs: registers hold, comb path follows.
    cycle(1, 1, 1, 0, 0);
    check("hold_out_vld", {31'd0, out_vld}, 32'd0);
    check("hold_s_q", {31'd0, s_q}, 32'd1);
    check("hold_co_q", {31'd0, co_q}, 32'd0);
    check("hold_cnt", {24'd0, carry_cnt}, 32'd1);
    check("hold_comb111", {30'd0, co, s}, 32'd3);
    cycle(0, 1, 1, 0, 0);
    check("hold2_s_q", {31'd0, s_q}, 32'd1);
    check("hold2_co_q", {31'd0, co_q}, 32'd0);
    check("hold2_cnt", {24'd0, carry_cnt}, 32'd1);
    check("hold_comb011", {30'd0, co, s}, 32'd2);
    #2 a = 0; b = 0; ci = 1;
    #1 check("mid_comb001", {30'd0, co, s}, 32'd1);

    // Saturation: 300 carries on top of count 1.
    for (int i = 0; i < 253; i++) cycle(1, 1, 1, 1, 0);
    check("sat_254", {24'd0, carry_cnt}, 32'd254);
    cycle(1, 1, 1, 1, 0);
    check("sat_255", {24'd0, carry_cnt}, 32'd255);
    for (int i = 0; i < 46; i++) cycle(1, 1, 1, 1, 0);
    check("sat_hold", {24'd0, carry_cnt}, 32'd255);
    check("sat_s_q", {31'd0, s_q}, 32'd1);
    check("sat_co_q", {31'd0, co_q}, 32'd1);

    // Clear together with a carry: clear wins.
    cycle(1, 1, 1, 1, 1);
    check("clr_prio", {24'd0, carry_cnt}, 32'd0);
    check("clr_out_vld", {31'd0, out_vld}, 32'd1);
    cycle(0, 1, 1, 1, 0);
    check("post_clr_cnt", {24'd0, carry_cnt}, 32'd1);
    cycle(0, 0, 0, 0, 1);
    check("clr_alone", {24'd0, carry_cnt}, 32'd0);

    // Build some state, then reset asynchronously mid-cycle.
    cycle(1, 1, 0, 1, 0);
    cycle(1, 0, 1, 1, 0);
    a = 1; b = 1; ci = 1; in_vld = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_s_q", {31'd0, s_q}, 32'd0);
    check("arst_co_q", {31'd0, co_q}, 32'd0);
    check("arst_out_vld", {31'd0, out_vld}, 32'd0);
    check("arst_cnt", {24'd0, carry_cnt}, 32'd0);
    check("arst_comb111", {30'd0, co, s}, 32'd3);
    a = 0; b = 1; ci = 0;
    #1 check("arst_comb010", {30'd0, co, s}, 32'd1);
    in_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset release operates normally.
    cycle(0, 1, 1, 1, 0);
    check("rel_s_q", {31'd0, s_q}, 32'd0);
    check("rel_co_q", {31'd0, co_q}, 32'd1);
    check("rel_out_vld", {31'd0, out_vld}, 32'd1);
    check("rel_cnt", {24'd0, carry_cnt}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the carry-event counter.
REQ-002 The block SHALL have port clk  input  1  single clock; all registers update on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port a  input  1  addend bit A.
REQ-005 The block SHALL have port b  input  1  addend bit B.
REQ-006 The block SHALL have port ci  input  1  carry-in.
REQ-007 The block SHALL have port in_vld  input  1  qualifies a, b and ci for the registered path and the counter.
REQ-008 The block SHALL have port cnt_clr  input  1  synchronous clear of carry_cnt.
REQ-009 The block SHALL have port s  output  1  combinational sum.
REQ-010 The block SHALL have port co  output  1  combinational carry-out.
REQ-011 The block SHALL have port s_q  output  1  registered sum.
REQ-012 The block SHALL have port co_q  output  1  registered carry-out.
REQ-013 The block SHALL have port out_vld  output  1  qualifies s_q and co_q.
REQ-014 The block SHALL have port carry_cnt  output  CNT_W  saturating count of accepted inputs that produced co=1.

Function
REQ-015 s SHALL equal a XOR b XOR ci at all times, with no clock dependency.
REQ-016 co SHALL equal (a AND b) OR (a AND ci) OR (b AND ci) at all times, with no clock dependency.
REQ-017 s and co SHALL be purely combinational and SHALL be unaffected by rst_n, in_vld and cnt_clr.
REQ-018 The 2-bit sum {co,s} SHALL equal a+b+ci for all 8 input combinations.
REQ-019 On a rising clk edge with in_vld=1, s_q and co_q SHALL load the current s and co, giving 1-cycle latency.
REQ-020 On a rising clk edge with in_vld=0, s_q and co_q SHALL hold their previous values.
REQ-021 out_vld SHALL be a 1-cycle-delayed copy of in_vld.
REQ-022 On a rising clk edge with in_vld=1 and co=1, carry_cnt SHALL increment by 1.
REQ-023 carry_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 When cnt_clr=1 on a rising clk edge, carry_cnt SHALL become 0.
REQ-025 When cnt_clr=1 and an increment condition occur on the same edge, the clear SHALL take priority and carry_cnt SHALL become 0.
REQ-026 Input changes between clock edges SHALL affect only s and co; the registered state SHALL sample inputs at the rising edge only.

Reset
REQ-027 While rst_n=0, s_q, co_q and out_vld SHALL be 0 and carry_cnt SHALL be 0, and these values SHALL take effect immediately without waiting for clk.
REQ-028 The first rising clk edge after rst_n deasserts SHALL operate normally.
REQ-029 If reset asserts during operation, registered state SHALL be lost, and s and co SHALL continue to follow the inputs.

Verification
REQ-030 Apply {a,b,ci} = 000, 001, 010, 011, 100, 101, 110, 111 in order, each held for 100 ns with no clock -> {co,s} = 00, 01, 01, 10, 01, 10, 10, 11.
REQ-031 With in_vld=1, apply a=1, b=1, ci=0 at one edge -> after that edge s_q=0, co_q=1, out_vld=1, and carry_cnt increments by 1.
REQ-032 With in_vld=0 and the inputs toggling -> s_q and co_q hold their values, out_vld=0, carry_cnt is unchanged, and s and co still follow the inputs.
REQ-033 Issue 300 accepted inputs with a=b=ci=1 and CNT_W=8 -> carry_cnt=255 and stays there; then assert cnt_clr together with another carry -> carry_cnt=0.
REQ-034 Assert rst_n=0 mid-stream between clock edges -> s_q, co_q, out_vld and carry_cnt are 0 immediately, while s and co keep tracking the inputs.
